uart_cmd_host: RTL and testbench

Host-side command initiator for the UART-controlled register-file/ALU system. It serializes one request at a time into the system's UART command frame byte stream, handing bytes to a UART TX byte interface. It collects the system's response bytes from a UART RX byte interface and returns one response word, with a timeout. It is used in bench harnesses and in host-side FPGA bridges, sitting between a request source and a UART_TX/UART_RX pair running on the same clock.

---
 rtl/uart_cmd_host.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_cmd_host.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_host.sv
// uart_cmd_host
//   Host-side command initiator. Accepts one request at a time, serializes it
//   into the UART command frame byte stream, then collects the response bytes
//   (LSB first) and returns a single response word, with an idle timeout.
//
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   REQ_VALID/READY    request handshake (READY only in IDLE, never in reset)
//   REQ_TYPE           0 RF write, 1 RF read, 2 ALU w/ operands, 3 ALU w/o
//   REQ_ADDR           register address (types 0/1)
//   REQ_DATA_A/B       write data / operand A, operand B
//   REQ_FUN            ALU function (types 2/3)
//   TX_DATA/VALID/READY  frame byte stream toward UART TX
//   RX_DATA/VALID      received byte stream from UART RX (1-cycle pulses)
//   RSP_VALID          one-cycle response pulse
//   RSP_DATA           response word, held until the next acceptance
//   RSP_TIMEOUT        response incomplete (qualifies RSP_VALID)
module uart_cmd_host #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic [1:0]              REQ_TYPE,
  input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]   REQ_DATA_A,
  input  logic [DATA_WIDTH-1:0]   REQ_DATA_B,
  input  logic [3:0]              REQ_FUN,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VALID,
  output logic                    RSP_VALID,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_TIMEOUT
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);

  localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] HDR_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] HDR_FUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RSP,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              type_q, type_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [3:0]              fun_q, fun_d;
  logic [1:0]              idx_q, idx_d;
  logic [1:0]              rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]           idle_q, idle_d;
  logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_to_q, rsp_to_d;

  logic [1:0]              frame_last;
  logic [1:0]              rsp_need;
  logic [1:0]              rx_cnt_inc;
  logic [DATA_WIDTH-1:0]   cur_byte;

  // Per-type frame length (as last byte index) and expected response bytes.
  always_comb begin
    frame_last = 2'd1;
    rsp_need   = 2'd2;
    unique case (type_q)
      2'd0: begin frame_last = 2'd2; rsp_need = 2'd0; end
      2'd1: begin frame_last = 2'd1; rsp_need = 2'd1; end
      2'd2: begin frame_last = 2'd3; rsp_need = 2'd2; end
      2'd3: begin frame_last = 2'd1; rsp_need = 2'd2; end
      default: ;
    endcase
  end

  // Frame byte selected by the latched request and the current byte index.
  always_comb begin
    cur_byte = '0;
    unique case (type_q)
      2'd0: begin
        unique case (idx_q)
          2'd0:    cur_byte = HDR_WR;
          2'd1:    cur_byte = DATA_WIDTH'(addr_q);
          2'd2:    cur_byte = a_q;
          default: cur_byte = '0;
        endcase
      end
      2'd1: begin
        unique case (idx_q)
          2'd0:    cur_byte = HDR_RD;
          2'd1:    cur_byte = DATA_WIDTH'(addr_q);
          default: cur_byte = '0;
        endcase
      end
      2'd2: begin
        unique case (idx_q)
          2'd0:    cur_byte = HDR_ALU;
          2'd1:    cur_byte = a_q;
          2'd2:    cur_byte = b_q;
          default: cur_byte = DATA_WIDTH'(fun_q);
        endcase
      end
      default: begin
        unique case (idx_q)
          2'd0:    cur_byte = HDR_FUN;
          2'd1:    cur_byte = DATA_WIDTH'(fun_q);
          default: cur_byte = '0;
        endcase
      end
    endcase
  end

  assign rx_cnt_inc = rx_cnt_q + 2'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      type_q     <= '0;
      addr_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      idx_q      <= '0;
      rx_cnt_q   <= '0;
      idle_q     <= '0;
      rsp_data_q <= '0;
      rsp_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      idx_q      <= idx_d;
      rx_cnt_q   <= rx_cnt_d;
      idle_q     <= idle_d;
      rsp_data_q <= rsp_data_d;
      rsp_to_q   <= rsp_to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    addr_d     = addr_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    idx_d      = idx_q;
    rx_cnt_d   = rx_cnt_q;
    idle_d     = idle_q;
    rsp_data_d = rsp_data_q;
    rsp_to_d   = rsp_to_q;

    REQ_READY   = 1'b0;
    TX_VALID    = 1'b0;
    TX_DATA     = '0;
    RSP_VALID   = 1'b0;
    RSP_DATA    = rsp_data_q;
    RSP_TIMEOUT = rsp_to_q;

    unique case (state_q)
      S_IDLE: begin
        REQ_READY = !RST;
        if (REQ_VALID && !RST) begin
          type_d     = REQ_TYPE;
          addr_d     = REQ_ADDR;
          a_d        = REQ_DATA_A;
          b_d        = REQ_DATA_B;
          fun_d      = REQ_FUN;
          idx_d      = '0;
          rx_cnt_d   = '0;
          idle_d     = '0;
          rsp_data_d = '0;
          rsp_to_d   = 1'b0;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        TX_VALID = 1'b1;
        TX_DATA  = cur_byte;
        if (TX_READY) begin
          if (idx_q == frame_last) begin
            idx_d   = '0;
            idle_d  = '0;
            state_d = (rsp_need == 2'd0) ? S_DONE : S_WAIT_RSP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      S_WAIT_RSP: begin
        // A byte on the expiry cycle wins over the timeout.
        if (RX_VALID) begin
          if (rx_cnt_q == 2'd0) begin
            rsp_data_d[DATA_WIDTH-1:0] = RX_DATA;
          end else begin
            rsp_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = RX_DATA;
          end
          rx_cnt_d = rx_cnt_inc;
          idle_d   = '0;
          if (rx_cnt_inc == rsp_need) begin
            state_d = S_DONE;
          end
        end else if (idle_q == IDLE_LAST) begin
          rsp_to_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          idle_d = idle_q + CW'(1);
        end
      end

      S_DONE: begin
        RSP_VALID = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Scoreboarded bench for uart_cmd_host: stimulus pushes expected TX bytes and
// responses; a negedge monitor pops and compares on every TX handshake and
// every RSP_VALID pulse.
module tb_uart_cmd_host;

  localparam int unsigned TO = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [1:0]  REQ_TYPE;
  logic [3:0]  REQ_ADDR;
  logic [7:0]  REQ_DATA_A;
  logic [7:0]  REQ_DATA_B;
  logic [3:0]  REQ_FUN;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RSP_VALID;
  logic [15:0] RSP_DATA;
  logic        RSP_TIMEOUT;

  uart_cmd_host #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .TIMEOUT   (TO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_TYPE   (REQ_TYPE),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_DATA_A (REQ_DATA_A),
    .REQ_DATA_B (REQ_DATA_B),
    .REQ_FUN    (REQ_FUN),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (RX_VALID),
    .RSP_VALID  (RSP_VALID),
    .RSP_DATA   (RSP_DATA),
    .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_tx[$];
  logic [16:0] exp_rsp[$];   // {timeout, data}

  int          hs_cnt = 0;
  logic        stall_q = 1'b0;
  logic [7:0]  held_q = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (stall_q) check("tx_hold", {23'b0, TX_VALID, TX_DATA}, {23'b0, 1'b1, held_q});
    stall_q = TX_VALID && !TX_READY;
    held_q  = TX_DATA;
    if (TX_VALID && TX_READY) begin
      hs_cnt++;
      if (exp_tx.size() == 0) begin
        check("tx_unexpected", {24'b0, TX_DATA}, 32'hFFFF_FFFF);
      end else begin
        check("tx_byte", {24'b0, TX_DATA}, {24'b0, exp_tx.pop_front()});
      end
    end
    if (RSP_VALID) begin
      if (exp_rsp.size() == 0) begin
        check("rsp_unexpected", {15'b0, RSP_TIMEOUT, RSP_DATA}, 32'hFFFF_FFFF);
      end else begin
        check("rsp_word", {15'b0, RSP_TIMEOUT, RSP_DATA}, {15'b0, exp_rsp.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic issue(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] f);
    int w = 0;
    @(negedge CLK);
    while (!REQ_READY && w < 100) begin
      @(negedge CLK);
      w++;
    end
    check("req_ready", {31'b0, REQ_READY}, 32'd1);
    REQ_TYPE = t; REQ_ADDR = ad; REQ_DATA_A = a; REQ_DATA_B = b; REQ_FUN = f;
    REQ_VALID = 1'b1;
    @(posedge CLK);
    #1;
    // Scramble request inputs: the DUT must use its latched copy.
    REQ_VALID = 1'b0;
    REQ_TYPE = ~t; REQ_ADDR = ~ad; REQ_DATA_A = ~a; REQ_DATA_B = ~b; REQ_FUN = ~f;
  endtask

  task automatic rx_byte(input logic [7:0] d);
    @(posedge CLK);
    #1;
    RX_VALID = 1'b1;
    RX_DATA  = d;
    @(posedge CLK);
    #1;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
  endtask

  task automatic wait_rsp(input int max_cyc, output int n);
    n = 0;
    while (n < max_cyc) begin
      @(negedge CLK);
      n++;
      if (RSP_VALID) break;
    end
  endtask

  int n;

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; REQ_TYPE = '0; REQ_ADDR = '0; REQ_DATA_A = '0;
    REQ_DATA_B = '0; REQ_FUN = '0; TX_READY = 1'b1; RX_DATA = '0; RX_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", {31'b0, REQ_READY}, 32'd0);
    check("rst_tx_valid",  {31'b0, TX_VALID}, 32'd0);
    check("rst_tx_data",   {24'b0, TX_DATA}, 32'd0);
    check("rst_rsp",       {14'b0, RSP_VALID, RSP_TIMEOUT, RSP_DATA}, 32'd0);
    @(posedge CLK); #1; RST = 1'b0;

    // RF write: AA 05 3C, response immediately after the frame
    exp_tx.push_back(8'hAA); exp_tx.push_back(8'h05); exp_tx.push_back(8'h3C);
    exp_rsp.push_back({1'b0, 16'h0000});
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0);
    wait_rsp(20, n);
    check("wr_rsp_latency", n, 32'd4);
    @(negedge CLK);
    check("wr_ready_after", {31'b0, REQ_READY}, 32'd1);

    // RF read: BB 02, one RX byte 81
    exp_tx.push_back(8'hBB); exp_tx.push_back(8'h02);
    exp_rsp.push_back({1'b0, 16'h0081});
    issue(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
    repeat (2) @(posedge CLK);
    rx_byte(8'h81);
    @(negedge CLK);
    check("rd_rsp_latency", {31'b0, RSP_VALID}, 32'd1);
    @(negedge CLK);
    check("rd_ready_after", {31'b0, REQ_READY}, 32'd1);
    check("rd_rsp_hold", {16'b0, RSP_DATA}, 32'h0081);

    // ALU with operands: CC 10 20 00, RX 30 00
    exp_tx.push_back(8'hCC); exp_tx.push_back(8'h10);
    exp_tx.push_back(8'h20); exp_tx.push_back(8'h00);
    exp_rsp.push_back({1'b0, 16'h0030});
    issue(2'd2, 4'h0, 8'h10, 8'h20, 4'h0);
    repeat (4) @(posedge CLK);
    rx_byte(8'h30);
    rx_byte(8'h00);
    @(negedge CLK);
    check("alu_rsp_latency", {31'b0, RSP_VALID}, 32'd1);

    // ALU without operands under TX back-pressure: DD 02, RX 5A 01
    exp_tx.push_back(8'hDD); exp_tx.push_back(8'h02);
    exp_rsp.push_back({1'b0, 16'h015A});
    hs_cnt = 0;
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h2);
    for (int i = 0; i < 6; i++) begin
      TX_READY = ((i % 3) == 2);
      @(posedge CLK);
      #1;
    end
    TX_READY = 1'b1;
    check("stall_handshakes", hs_cnt, 32'd2);
    rx_byte(8'h5A);
    rx_byte(8'h01);
    @(negedge CLK);
    check("fun_rsp_latency", {31'b0, RSP_VALID}, 32'd1);

    // Timeout after one byte: CC 01 02 03, RX 7F then silence
    exp_tx.push_back(8'hCC); exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h02); exp_tx.push_back(8'h03);
    exp_rsp.push_back({1'b1, 16'h007F});
    issue(2'd2, 4'h0, 8'h01, 8'h02, 4'h3);
    repeat (4) @(posedge CLK);
    rx_byte(8'h7F);
    wait_rsp(40, n);
    check("timeout_latency", n, TO + 1);

    // RX exactly on the expiry cycle completes normally: BB 03, RX C3
    exp_tx.push_back(8'hBB); exp_tx.push_back(8'h03);
    exp_rsp.push_back({1'b0, 16'h00C3});
    issue(2'd1, 4'h3, 8'h00, 8'h00, 4'h0);
    repeat (TO) @(posedge CLK);
    rx_byte(8'hC3);
    @(negedge CLK);
    check("expiry_rx_latency", {31'b0, RSP_VALID}, 32'd1);

    // Stray RX in IDLE and during SEND (incl. last handshake) are dropped
    rx_byte(8'hEE);
    exp_tx.push_back(8'hBB); exp_tx.push_back(8'h07);
    exp_rsp.push_back({1'b0, 16'h0044});
    issue(2'd1, 4'h7, 8'h00, 8'h00, 4'h0);
    check("rsp_cleared", {16'b0, RSP_DATA}, 32'h0);
    RX_VALID = 1'b1; RX_DATA = 8'h99;
    @(posedge CLK); #1;
    RX_DATA = 8'h98;
    @(posedge CLK); #1;
    RX_VALID = 1'b0; RX_DATA = 8'h00;
    @(posedge CLK);
    rx_byte(8'h44);
    @(negedge CLK);
    check("stray_rsp_latency", {31'b0, RSP_VALID}, 32'd1);

    // Reset mid-SEND: first two bytes go out, then abort with no response
    exp_tx.push_back(8'hCC); exp_tx.push_back(8'h11);
    issue(2'd2, 4'h0, 8'h11, 8'h22, 4'h4);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("midrst_req_ready", {31'b0, REQ_READY}, 32'd0);
    check("midrst_tx_valid",  {31'b0, TX_VALID}, 32'd0);
    check("midrst_tx_data",   {24'b0, TX_DATA}, 32'd0);
    check("midrst_rsp",       {14'b0, RSP_VALID, RSP_TIMEOUT, RSP_DATA}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_ready", {31'b0, REQ_READY}, 32'd1);
    repeat (10) @(negedge CLK);

    check("tx_queue_left",  exp_tx.size(), 32'd0);
    check("rsp_queue_left", exp_rsp.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
